// File: rtl/reg_file_onehot_pkg.sv
// Shared constants and helpers for the Mini SRC register file and its
// one-hot decoder consumers.
package reg_file_onehot_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 32;

  localparam int R0  = 0;
  localparam int R1  = 1;
  localparam int R2  = 2;
  localparam int R3  = 3;
  localparam int R4  = 4;
  localparam int R5  = 5;
  localparam int R6  = 6;
  localparam int R7  = 7;
  localparam int R8  = 8;
  localparam int R9  = 9;
  localparam int R10 = 10;
  localparam int R11 = 11;
  localparam int R12 = 12;
  localparam int R13 = 13;
  localparam int R14 = 14;
  localparam int R15 = 15;

  // Exactly one bit set; v & (v-1) clears the lowest set bit.
  function automatic logic is_onehot(input logic [NUM_REGS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/reg_file_onehot_onehot_check.sv
// Classifies a decoder select vector as idle (zero), one-hot, or malformed.
module onehot_check
  import reg_file_onehot_pkg::*;
(
  input  logic [NUM_REGS-1:0] vec_i,
  output logic                is_zero_o,
  output logic                is_onehot_o,
  output logic                is_multi_o
);

  assign is_zero_o   = (vec_i == '0);
  assign is_onehot_o = is_onehot(vec_i);
  assign is_multi_o  = !is_zero_o && !is_onehot_o;

endmodule

// File: rtl/reg_file_onehot.sv
// 16 x 32 register file driven by one-hot write/read selects, with registered
// read, write-to-read forwarding, R0 base-address rule and sticky select errors.
module reg_file_onehot
  import reg_file_onehot_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic [NUM_REGS-1:0] r_in,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [NUM_REGS-1:0] r_out,
  input  logic                rd_en,
  input  logic                ba_out,
  input  logic                err_clr,
  output logic [DATA_W-1:0]   bus_out,
  output logic                rd_valid,
  output logic                wr_err,
  output logic                rd_err
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] bus_q, bus_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_err_q, rd_err_d;

  logic wr_zero, wr_onehot, wr_multi;
  logic rd_zero, rd_onehot, rd_multi;

  onehot_check u_wr_chk (
    .vec_i       (r_in),
    .is_zero_o   (wr_zero),
    .is_onehot_o (wr_onehot),
    .is_multi_o  (wr_multi)
  );

  onehot_check u_rd_chk (
    .vec_i       (r_out),
    .is_zero_o   (rd_zero),
    .is_onehot_o (rd_onehot),
    .is_multi_o  (rd_multi)
  );

  logic              wr_ok, rd_ok, fwd, ba_zero;
  logic [DATA_W-1:0] rd_mux;

  assign wr_ok   = wr_en && wr_onehot;
  assign rd_ok   = rd_en && rd_onehot;
  assign fwd     = wr_ok && (r_in == r_out);
  assign ba_zero = ba_out && r_out[R0];

  // Selects are one-hot when rd_ok is set, so an AND-OR mux suffices.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (r_out[k]) rd_mux = rd_mux | regs_q[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = (wr_ok && r_in[k]) ? wr_data : regs_q[k];
    end

    bus_d      = bus_q;
    rd_valid_d = 1'b0;
    if (rd_en) begin
      if (!rd_ok || ba_zero) bus_d = '0;
      else if (fwd)          bus_d = wr_data;
      else                   bus_d = rd_mux;
      rd_valid_d = rd_ok;
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    wr_err_d = (wr_en && wr_multi) || (wr_err_q && !err_clr);
    rd_err_d = (rd_en && rd_multi) || (rd_err_q && !err_clr);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      bus_q      <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
      bus_q      <= bus_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign bus_out  = bus_q;
  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;
  assign rd_err   = rd_err_q;

  logic unused_zero;
  assign unused_zero = wr_zero ^ rd_zero;

endmodule

// File: tb/tb_reg_file_onehot.sv
// Randomised and directed bench for reg_file_onehot against a behavioural model.
module tb_reg_file_onehot;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [15:0] r_in, r_out;
  logic        wr_en, rd_en, ba_out, err_clr;
  logic [31:0] wr_data;
  logic [31:0] bus_out;
  logic        rd_valid, wr_err, rd_err;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  reg_file_onehot #(.DATA_W(32), .NUM_REGS(16)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .r_in     (r_in),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .r_out    (r_out),
    .rd_en    (rd_en),
    .ba_out   (ba_out),
    .err_clr  (err_clr),
    .bus_out  (bus_out),
    .rd_valid (rd_valid),
    .wr_err   (wr_err),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain array of registers and expected outputs.
  logic [31:0] m_regs [16];
  logic [31:0] m_bus;
  logic        m_vld, m_werr, m_rerr;

  function automatic int sel_index(input logic [15:0] v);
    int idx;
    idx = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < 16; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
      m_bus  = 32'h0;
      m_vld  = 1'b0;
      m_werr = 1'b0;
      m_rerr = 1'b0;
    end else begin
      int wi, ri;
      wi = wr_en ? sel_index(r_in) : -1;
      ri = sel_index(r_out);
      if (rd_en) begin
        if (ri < 0)                  begin m_bus = 32'h0; m_vld = 1'b0; end
        else if (ri == 0 && ba_out)  begin m_bus = 32'h0; m_vld = 1'b1; end
        else if (wi == ri)           begin m_bus = wr_data; m_vld = 1'b1; end
        else                         begin m_bus = m_regs[ri]; m_vld = 1'b1; end
      end else begin
        m_vld = 1'b0;
      end
      if (wr_en && $countones(r_in) >= 2) m_werr = 1'b1;
      else if (err_clr)                   m_werr = 1'b0;
      if (rd_en && $countones(r_out) >= 2) m_rerr = 1'b1;
      else if (err_clr)                    m_rerr = 1'b0;
      if (wi >= 0) m_regs[wi] = wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_out", bus_out, m_bus);
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_vld});
      chk("wr_err", {31'b0, wr_err}, {31'b0, m_werr});
      chk("rd_err", {31'b0, rd_err}, {31'b0, m_rerr});
    end
  end

  // Apply one cycle of inputs; returns at the next falling edge.
  task automatic step(input logic we, input logic [15:0] ri, input logic [31:0] wd,
                      input logic re, input logic [15:0] ro, input logic ba,
                      input logic ec);
    wr_en = we; r_in = ri; wr_data = wd;
    rd_en = re; r_out = ro; ba_out = ba; err_clr = ec;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic wr(input int k, input logic [31:0] d);
    step(1'b1, 16'(1) << k, d, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input int k, input logic ba);
    step(1'b0, 16'h0, 32'h0, 1'b1, 16'(1) << k, ba, 1'b0);
  endtask

  initial begin
    clr_n = 1'b0;
    wr_en = 0; rd_en = 0; ba_out = 0; err_clr = 0;
    r_in = 0; r_out = 0; wr_data = 0;
    repeat (2) @(negedge clk);
    chk("reset bus_out", bus_out, 32'h0);
    chk("reset flags", {29'b0, rd_valid, wr_err, rd_err}, 32'h0);
    clr_n  = 1'b1;
    chk_en = 1'b1;

    // Asynchronous reset mid-cycle
    wr(5, 32'hDEADBEEF);
    rd(5, 1'b0);
    chk("R5 before reset", bus_out, 32'hDEADBEEF);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("async reset bus", bus_out, 32'h0);
    chk("async reset flags", {29'b0, rd_valid, wr_err, rd_err}, 32'h0);
    @(negedge clk);
    clr_n = 1'b1;
    rd(5, 1'b0);
    chk("R5 after reset", bus_out, 32'h0);
    chk("R5 after reset vld", {31'b0, rd_valid}, 32'h1);

    // Write then read
    wr(3, 32'h12345678);
    rd(3, 1'b0);
    chk("R3 read", bus_out, 32'h12345678);
    chk("R3 vld", {31'b0, rd_valid}, 32'h1);

    // Forwarding
    wr(7, 32'h1);
    step(1'b1, 16'h0080, 32'hCAFEF00D, 1'b1, 16'h0080, 1'b0, 1'b0);
    chk("fwd R7", bus_out, 32'hCAFEF00D);
    rd(7, 1'b0);
    chk("R7 after fwd", bus_out, 32'hCAFEF00D);

    // R0 base-address rule, including forwarding into R0
    wr(0, 32'hAAAA5555);
    rd(0, 1'b1);
    chk("R0 ba=1", bus_out, 32'h0);
    chk("R0 ba=1 vld", {31'b0, rd_valid}, 32'h1);
    rd(0, 1'b0);
    chk("R0 ba=0", bus_out, 32'hAAAA5555);
    step(1'b1, 16'h0001, 32'h11110000, 1'b1, 16'h0001, 1'b1, 1'b0);
    chk("R0 fwd ba=1", bus_out, 32'h0);

    // Malformed selects
    wr(1, 32'h11); wr(2, 32'h22);
    step(1'b1, 16'h0006, 32'hFFFFFFFF, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("wr_err set", {31'b0, wr_err}, 32'h1);
    rd(1, 1'b0);
    chk("R1 unchanged", bus_out, 32'h11);
    rd(2, 1'b0);
    chk("R2 unchanged", bus_out, 32'h22);
    step(1'b0, 16'h0, 32'h0, 1'b1, 16'h8001, 1'b0, 1'b0);
    chk("bad rd bus", bus_out, 32'h0);
    chk("bad rd flags", {29'b0, rd_valid, wr_err, rd_err}, 32'h3);
    idle();
    chk("flags sticky", {30'b0, wr_err, rd_err}, 32'h3);
    step(1'b1, 16'h0006, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("clr vs new wr_err", {30'b0, wr_err, rd_err}, 32'h2);
    step(1'b0, 16'h0006, 32'h0, 1'b0, 16'h8001, 1'b0, 1'b1);
    chk("flags cleared", {30'b0, wr_err, rd_err}, 32'h0);

    // Idle decoder with write strobe: nothing changes, bus holds
    rd(3, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 16'h0, 32'hBADBAD00, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("idle bus hold", bus_out, 32'h12345678);
    chk("idle flags", {29'b0, rd_valid, wr_err, rd_err}, 32'h0);
    rd(7, 1'b0);
    chk("idle R7 kept", bus_out, 32'hCAFEF00D);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ri, ro;
      int kw, kr;
      kw = $urandom_range(0, 15);
      kr = ($urandom_range(0, 3) == 0) ? kw : $urandom_range(0, 15);
      case ($urandom_range(0, 9))
        0:       ri = 16'h0;
        1:       ri = 16'($urandom) | 16'h0003;
        default: ri = 16'(1) << kw;
      endcase
      case ($urandom_range(0, 9))
        0:       ro = 16'h0;
        1:       ro = 16'($urandom) | 16'h8100;
        default: ro = 16'(1) << kr;
      endcase
      step(1'($urandom), ri, $urandom, 1'($urandom_range(0, 3) != 0), ro,
           1'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_onehot.md
Name: reg_file_onehot

Overview:
- 16 x 32-bit general-purpose register file for the Mini SRC datapath.
- Sits directly downstream of the 4-to-16 register-select decoders and consumes their one-hot vectors.
  - One vector selects the write target.
  - One vector selects the register driven onto the internal bus.
- Adds registered read, write-to-read forwarding, the R0 base-address rule, and sticky detection of malformed (non-one-hot) select vectors.

Parameters:
- DATA_W, 32, register and bus width.
- NUM_REGS, 16, register count; fixed to match decoder output width.

Ports:
- clk  input  1  system clock, rising-edge active.
- clr_n  input  1  asynchronous active-low reset.
- r_in  input  NUM_REGS  one-hot write-select from the write decoder.
- wr_en  input  1  write strobe; qualifies r_in.
- wr_data  input  DATA_W  data written to the selected register.
- r_out  input  NUM_REGS  one-hot read-select from the read decoder.
- rd_en  input  1  read strobe; qualifies r_out.
- ba_out  input  1  base-address mode; when set, a read of R0 returns 0.
- err_clr  input  1  clears sticky error flags.
- bus_out  output  DATA_W  registered read data.
- rd_valid  output  1  bus_out holds data from a read accepted the previous cycle.
- wr_err  output  1  sticky: write attempted with r_in not exactly one-hot.
- rd_err  output  1  sticky: read attempted with r_out not exactly one-hot.

Behaviour:
- Reset (clr_n low, asynchronous, any time):
  - all 16 registers = 0; bus_out = 0; rd_valid = 0; wr_err = 0; rd_err = 0.
  - Reset mid-operation discards any write or read in flight; there is no partial update.
- Write, evaluated on the rising clk edge when wr_en = 1:
  - r_in exactly one-hot (popcount 1): register k (bit k set) <= wr_data.
  - r_in = 0: no write, no error (idle decoder).
  - r_in popcount >= 2: no register modified; wr_err <= 1.
  - wr_en = 0: r_in is ignored entirely; no error check.
- Read, evaluated on the rising clk edge when rd_en = 1; latency 1 cycle:
  - r_out one-hot selecting k: bus_out <= value of register k; rd_valid <= 1.
  - k = 0 with ba_out = 1: bus_out <= 0 regardless of R0 contents; R0 is still writable.
  - r_out = 0 or popcount >= 2: bus_out <= 0; rd_valid <= 0.
    - popcount >= 2 additionally sets rd_err <= 1.
  - rd_en = 0: bus_out holds its previous value; rd_valid <= 0.
- Simultaneous write and read of the same register k in one cycle: forwarding applies, so bus_out <= wr_data (new value).
  - Exception: k = 0 with ba_out = 1 still returns 0.
- Simultaneous write and read of different registers are independent.
- Error flags:
  - Sticky until err_clr = 1 at a clock edge.
  - If err_clr and a new error condition coincide, the new error wins (flag stays 1).
  - The error check runs every cycle and does not depend on rd_valid.
- One-hot check: popcount-free form, v != 0 && (v & (v-1)) == 0; purely combinational on registered-free inputs.
- No combinational path from inputs to any output.

Decomposition:
- Shared package constants:
  - NUM_REGS = 16, DATA_W = 32.
  - Register index constants R0..R15.
  - Function is_onehot(vector), used here and by future one-hot consumers (bus multiplexer).
- One natural sub-module, onehot_check: input vector; outputs is_zero, is_onehot, is_multi.
  - Instantiated twice, once for r_in and once for r_out.

Test Plan:
- Reset: load R5 = 0xDEADBEEF, then pulse clr_n low mid-cycle -> all outputs 0 immediately; a read of R5 after release returns 0x00000000 with rd_valid = 1.
- Write/read: write R3 = 0x12345678 (r_in = 0x0008), next cycle read r_out = 0x0008 -> bus_out = 0x12345678 one cycle later, rd_valid = 1.
- Forwarding: R7 holds 0x1; in the same cycle write R7 = 0xCAFEF00D and read R7 -> bus_out = 0xCAFEF00D next cycle; a following read also returns 0xCAFEF00D.
- R0 rule: write R0 = 0xAAAA5555:
  - read with ba_out = 1 -> bus_out = 0.
  - read with ba_out = 0 -> bus_out = 0xAAAA5555.
- Malformed selects:
  - wr_en = 1 with r_in = 0x0006 -> R1 and R2 unchanged, wr_err = 1.
  - rd_en = 1 with r_out = 0x8001 -> bus_out = 0, rd_valid = 0, rd_err = 1.
  - Both flags hold until err_clr; err_clr together with a new bad r_in leaves wr_err = 1.
- Idle: wr_en = 1 with r_in = 0 and rd_en = 0 for 10 cycles -> no register changes, no error flags, bus_out holds its last value.
